blackjack_uart_reporter: RTL and testbench
==========================================

// Module: blackjack_uart_reporter
// PURPOSE
//   Reads the game core's result outputs (user_total, dealer_total, balance) and streams them off-chip as
//   8N1 UART ASCII frames.
//   A frame is sent whenever any value changes or a report is forced.
//   Frame: "U<uu> D<dd> B<bbbb>\r\n", 15 bytes, decimal, zero-padded.
//   Sits between blackjack_core and the board TX pin.
// PARAMETERS
//   CLKS_PER_BIT  217  clk cycles per UART bit (25 MHz / 115200); minimum legal value 2
// PORTS
//   clk           in   1   system clock
//   rst_n         in   1   asynchronous active-low reset
//   user_total    in   6   player total from core, binary
//   dealer_total  in   6   dealer total from core, binary
//   balance       in   10  player balance from core, binary, 0..1023
//   force_report  in   1   single-cycle pulse: send a frame even if nothing changed
//   tx            out  1   UART serial out; idles high
//   busy          out  1   high from frame capture until the end of the last stop bit
// BEHAVIOUR
//   Reset (async, rst_n=0)
//   - tx=1, busy=0, state=IDLE, force_pend=0, all counters 0.
//   - Snapshot regs are set to all-ones (63/63/1023). The first IDLE cycle after reset therefore normally
//     triggers a frame.
//   States
//   - IDLE -> CONVERT -> SEND -> IDLE.
//   IDLE
//   - Triggers on (inputs != snapshot) OR force_report OR force_pend.
//   - On the trigger edge (cycle 0): latch all three inputs into the snapshot, clear force_pend, set busy=1,
//     enter CONVERT.
//   CONVERT
//   - Sequential double-dabble on the snapshot balance: exactly 10 cycles, 4 BCD digits.
//   - user/dealer are converted combinationally to tens/ones digits; values are <=63, so 2 digits suffice.
//   SEND
//   - Sends bytes 0..14 back-to-back with no idle gap.
//   - Each byte is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts CLKS_PER_BIT cycles.
//   - The start bit of byte 0 appears on tx at cycle 11 after the trigger edge.
//   - Byte order: 'U',u1,u0,' ','D',d1,d0,' ','B',b3,b2,b1,b0,8'h0D,8'h0A.
//   - Digits are encoded as 8'h30 + digit.
//   Frame end
//   - After the last stop-bit period the block returns to IDLE and busy=0.
//   - busy stays high for 11 + 150*CLKS_PER_BIT cycles in total.
//   - tx is registered and glitch-free; tx=1 in every non-SEND state.
//   Input changes while busy
//   - Not sampled.
//   - The next IDLE compares the current inputs against the snapshot. Only the latest value is reported;
//     intermediate values are dropped by design.
//   force_report while busy
//   - Sets force_pend. Exactly one extra frame is sent when the block returns to IDLE, even if a change
//     trigger also fires (the two triggers merge).
//   Simultaneous change and force_report in IDLE
//   - One frame only.
//   Frame content
//   - The frame always shows the snapshot captured at trigger time. Inputs changing mid-frame never corrupt
//     the bytes being sent.
//   Reset mid-frame
//   - tx=1 and busy=0 immediately. The partial frame is abandoned.
//   - The snapshot re-arms, so a full new frame starts after rst_n is released.
//   Width rules
//   - No saturation is needed: 6-bit values are at most 63 and 10-bit values at most 1023. Digits are
//     always valid BCD.
// TESTING (CLKS_PER_BIT=4 in sim; decode tx with a bench UART RX model)
//   1. Release reset with U=0, D=0, B=500.
//      -> exactly one frame "U00 D00 B0500\r\n"; tx=1 and busy=0 while in reset.
//   2. Idle, then set user_total=21.
//      -> frame "U21 D00 B0500\r\n"; tx low 11 cycles after the capture edge; busy high exactly 611 cycles.
//   3. During a frame, change balance 500->550->450->400.
//      -> after the current frame, exactly one frame "...B0400"; no other frames.
//   4a. force_report pulse with unchanged inputs.
//       -> identical frame is re-sent.
//   4b. force_report pulse while busy.
//       -> exactly one extra frame after the current one.
//   5. U=31, D=27, B=1023, then B=0.
//      -> frame "U31 D27 B1023\r\n", then frame "U31 D27 B0000\r\n".
//   6. Assert rst_n low in the middle of byte 5.
//      -> tx=1 and busy=0 in the same cycle; after release, a complete fresh frame with no truncated bytes.

Source files
------------

// File: rtl/blackjack_uart_reporter.sv
// Streams the game core's totals and balance as "U<uu> D<dd> B<bbbb>\r\n" 8N1 UART frames
// whenever a value changes or a report is forced.
module blackjack_uart_reporter #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] user_total,
    input  logic [5:0] dealer_total,
    input  logic [9:0] balance,
    input  logic       force_report,
    output logic       tx,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CONVERT, SEND} state_t;

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    state_t        state, state_next;
    logic [5:0]    snap_user, snap_user_next;
    logic [5:0]    snap_dealer, snap_dealer_next;
    logic [9:0]    snap_bal, snap_bal_next;
    logic          force_pend, force_pend_next;
    logic          busy_next, tx_next;
    logic [9:0]    dd_bin, dd_bin_next;
    logic [15:0]   dd_bcd, dd_bcd_next;
    logic [3:0]    step_cnt, step_cnt_next;
    logic [CW-1:0] clk_cnt, clk_cnt_next;
    logic [3:0]    bit_idx, bit_idx_next;
    logic [3:0]    byte_idx, byte_idx_next;

    logic          trigger;
    logic [11:0]   adj;
    logic [7:0]    cur_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            snap_user   <= '1;
            snap_dealer <= '1;
            snap_bal    <= '1;
            force_pend  <= 1'b0;
            busy        <= 1'b0;
            tx          <= 1'b1;
            dd_bin      <= '0;
            dd_bcd      <= '0;
            step_cnt    <= '0;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
        end else begin
            state       <= state_next;
            snap_user   <= snap_user_next;
            snap_dealer <= snap_dealer_next;
            snap_bal    <= snap_bal_next;
            force_pend  <= force_pend_next;
            busy        <= busy_next;
            tx          <= tx_next;
            dd_bin      <= dd_bin_next;
            dd_bcd      <= dd_bcd_next;
            step_cnt    <= step_cnt_next;
            clk_cnt     <= clk_cnt_next;
            bit_idx     <= bit_idx_next;
            byte_idx    <= byte_idx_next;
        end
    end

    // Frame byte for the byte currently on the wire.
    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx)
            4'd0:  cur_byte = 8'h55;
            4'd1:  cur_byte = 8'h30 + ({2'b00, snap_user} / 8'd10);
            4'd2:  cur_byte = 8'h30 + ({2'b00, snap_user} % 8'd10);
            4'd3:  cur_byte = 8'h20;
            4'd4:  cur_byte = 8'h44;
            4'd5:  cur_byte = 8'h30 + ({2'b00, snap_dealer} / 8'd10);
            4'd6:  cur_byte = 8'h30 + ({2'b00, snap_dealer} % 8'd10);
            4'd7:  cur_byte = 8'h20;
            4'd8:  cur_byte = 8'h42;
            4'd9:  cur_byte = 8'h30 + {4'h0, dd_bcd[15:12]};
            4'd10: cur_byte = 8'h30 + {4'h0, dd_bcd[11:8]};
            4'd11: cur_byte = 8'h30 + {4'h0, dd_bcd[7:4]};
            4'd12: cur_byte = 8'h30 + {4'h0, dd_bcd[3:0]};
            4'd13: cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_next       = state;
        snap_user_next   = snap_user;
        snap_dealer_next = snap_dealer;
        snap_bal_next    = snap_bal;
        force_pend_next  = force_pend;
        busy_next        = busy;
        tx_next          = 1'b1;
        dd_bin_next      = dd_bin;
        dd_bcd_next      = dd_bcd;
        step_cnt_next    = step_cnt;
        clk_cnt_next     = clk_cnt;
        bit_idx_next     = bit_idx;
        byte_idx_next    = byte_idx;
        adj              = dd_bcd[11:0];

        trigger = force_report || force_pend ||
                  ({user_total, dealer_total, balance} != {snap_user, snap_dealer, snap_bal});

        case (state)
            IDLE: begin
                if (trigger) begin
                    snap_user_next   = user_total;
                    snap_dealer_next = dealer_total;
                    snap_bal_next    = balance;
                    force_pend_next  = 1'b0;
                    busy_next        = 1'b1;
                    dd_bin_next      = balance;
                    dd_bcd_next      = '0;
                    step_cnt_next    = '0;
                    state_next       = CONVERT;
                end
            end
            CONVERT: begin
                if (force_report) force_pend_next = 1'b1;
                if (step_cnt != 4'd10) begin
                    // Thousands digit never reaches 5 for a 10-bit input, so only three digits are adjusted.
                    for (int unsigned i = 0; i < 3; i++) begin
                        if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
                    end
                    dd_bcd_next   = {dd_bcd[14:12], adj, dd_bin[9]};
                    dd_bin_next   = {dd_bin[8:0], 1'b0};
                    step_cnt_next = step_cnt + 4'd1;
                end else begin
                    // Eleventh cycle launches the start bit of byte 0.
                    state_next    = SEND;
                    clk_cnt_next  = '0;
                    bit_idx_next  = '0;
                    byte_idx_next = '0;
                    tx_next       = 1'b0;
                end
            end
            SEND: begin
                if (force_report) force_pend_next = 1'b1;
                tx_next = tx;
                if (clk_cnt != CNT_MAX) begin
                    clk_cnt_next = clk_cnt + CW'(1);
                end else begin
                    clk_cnt_next = '0;
                    if (bit_idx != 4'd9) begin
                        bit_idx_next = bit_idx + 4'd1;
                        tx_next      = (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
                    end else if (byte_idx != 4'd14) begin
                        byte_idx_next = byte_idx + 4'd1;
                        bit_idx_next  = '0;
                        tx_next       = 1'b0;
                    end else begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_blackjack_uart_reporter.sv
// Bench for blackjack_uart_reporter: a UART receiver model decodes tx and frames are
// compared against strings formatted from the values the bench applied.
module tb_blackjack_uart_reporter;

    localparam int unsigned CPB = 4;

    logic       clk;
    logic       rst_n;
    logic [5:0] user_total;
    logic [5:0] dealer_total;
    logic [9:0] balance;
    logic       force_report;
    logic       tx;
    logic       busy;

    int errors = 0;
    int checks = 0;

    int cur_u, cur_d, cur_b;

    byte unsigned rx_q[$];
    int           rx_ferr = 0;
    bit           rx_active = 0;
    int unsigned  rx_cnt = 0;
    logic [7:0]   rx_sh = '0;

    blackjack_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .user_total   (user_total),
        .dealer_total (dealer_total),
        .balance      (balance),
        .force_report (force_report),
        .tx           (tx),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART receiver: bit k of a byte is sampled CPB*k+1 negedges after the start edge is seen.
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active = 0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == 1) begin
                if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) begin
                    rx_sh[rx_cnt / CPB - 1] = tx;
                end else if (rx_cnt / CPB == 9) begin
                    if (tx !== 1'b1) rx_ferr++;
                    else rx_q.push_back(rx_sh);
                    rx_active = 0;
                end
            end
        end
    end

    function automatic string frame(int u, int d, int b);
        return $sformatf("U%02d D%02d B%04d%c%c", u, d, b, 8'h0D, 8'h0A);
    endfunction

    function automatic string rx_str();
        string s = "";
        foreach (rx_q[i]) s = $sformatf("%s%c", s, rx_q[i]);
        return s;
    endfunction

    function automatic string shown(string s);
        string r = "";
        byte   c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == 8'h0D)      r = {r, "\\r"};
            else if (c == 8'h0A) r = {r, "\\n"};
            else                 r = $sformatf("%s%c", r, c);
        end
        return r;
    endfunction

    task automatic set_in(input int u, input int d, input int b);
        @(negedge clk);
        cur_u = u; cur_d = d; cur_b = b;
        user_total   = 6'(u);
        dealer_total = 6'(d);
        balance      = 10'(b);
    endtask

    task automatic pulse_force();
        @(negedge clk);
        force_report = 1'b1;
        @(negedge clk);
        force_report = 1'b0;
    endtask

    task automatic wait_quiet(output bit timed_out);
        int idle = 0;
        timed_out = 1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) idle++;
            else idle = 0;
            if (idle >= 30) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit to;
        string got, exp;
        rst_n = 1'b0;
        force_report = 1'b0;
        cur_u = 0; cur_d = 0; cur_b = 500;
        user_total = 6'd0; dealer_total = 6'd0; balance = 10'd500;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        rx_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        wait_quiet(to);
        checks++;
        if (to) begin errors++; $display("FAIL reset_timeout: busy did not settle"); end
        got = rx_str();
        exp = frame(0, 0, 500);
        checks++;
        if (got != exp) begin errors++; $display("FAIL reset_frame: got '%s' required '%s'", shown(got), shown(exp)); end
    endtask

    task automatic test_latency();
        bit to;
        int low_k = 0, busy_k = 0;
        string got, exp;
        rx_q.delete();
        set_in(21, 0, 500);
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL latency_busy_rise: got %b required 1", busy); end
        for (int k = 1; k < 2000; k++) begin
            @(posedge clk);
            #1;
            if (low_k == 0 && tx === 1'b0) low_k = k;
            if (busy === 1'b0) begin
                busy_k = k;
                break;
            end
        end
        checks++;
        if (low_k != 11) begin errors++; $display("FAIL latency_start_bit: got %0d required 11", low_k); end
        checks++;
        if (busy_k != 11 + 150 * CPB) begin errors++; $display("FAIL latency_busy_len: got %0d required %0d", busy_k, 11 + 150 * CPB); end
        wait_quiet(to);
        checks++;
        if (to) begin errors++; $display("FAIL latency_timeout: busy did not settle"); end
        got = rx_str();
        exp = frame(21, 0, 500);
        checks++;
        if (got != exp) begin errors++; $display("FAIL latency_frame: got '%s' required '%s'", shown(got), shown(exp)); end
    endtask

    task automatic test_mid_frame_changes();
        bit to;
        string got, exp;
        rx_q.delete();
        pulse_force();
        repeat (100) @(negedge clk);
        set_in(21, 0, 550);
        repeat (100) @(negedge clk);
        set_in(21, 0, 450);
        repeat (100) @(negedge clk);
        set_in(21, 0, 400);
        wait_quiet(to);
        checks++;
        if (to) begin errors++; $display("FAIL midchange_timeout: busy did not settle"); end
        got = rx_str();
        exp = {frame(21, 0, 500), frame(21, 0, 400)};
        checks++;
        if (got != exp) begin errors++; $display("FAIL midchange_frames: got '%s' required '%s'", shown(got), shown(exp)); end
    endtask

    task automatic test_force();
        bit to;
        string got, exp;
        rx_q.delete();
        pulse_force();
        wait_quiet(to);
        checks++;
        if (to) begin errors++; $display("FAIL force_idle_timeout: busy did not settle"); end
        got = rx_str();
        exp = frame(21, 0, 400);
        checks++;
        if (got != exp) begin errors++; $display("FAIL force_idle_frame: got '%s' required '%s'", shown(got), shown(exp)); end

        rx_q.delete();
        pulse_force();
        repeat (200) @(negedge clk);
        pulse_force();
        wait_quiet(to);
        checks++;
        if (to) begin errors++; $display("FAIL force_busy_timeout: busy did not settle"); end
        got = rx_str();
        exp = {frame(21, 0, 400), frame(21, 0, 400)};
        checks++;
        if (got != exp) begin errors++; $display("FAIL force_busy_frames: got '%s' required '%s'", shown(got), shown(exp)); end
    endtask

    task automatic test_back_to_back();
        bit to;
        string got, exp;
        rx_q.delete();
        pulse_force();
        repeat (50) @(negedge clk);
        set_in(5, 0, 400);
        pulse_force();
        wait_quiet(to);
        checks++;
        if (to) begin errors++; $display("FAIL merge_timeout: busy did not settle"); end
        got = rx_str();
        exp = {frame(21, 0, 400), frame(5, 0, 400)};
        checks++;
        if (got != exp) begin errors++; $display("FAIL merge_frames: got '%s' required '%s'", shown(got), shown(exp)); end
    endtask

    task automatic test_extremes();
        bit to;
        string got, exp;
        int vals[3][3] = '{'{31, 27, 1023}, '{31, 27, 0}, '{63, 63, 1023}};
        for (int i = 0; i < 3; i++) begin
            rx_q.delete();
            set_in(vals[i][0], vals[i][1], vals[i][2]);
            wait_quiet(to);
            checks++;
            if (to) begin errors++; $display("FAIL extreme_timeout_%0d: busy did not settle", i); end
            got = rx_str();
            exp = frame(vals[i][0], vals[i][1], vals[i][2]);
            checks++;
            if (got != exp) begin errors++; $display("FAIL extreme_frame_%0d: got '%s' required '%s'", i, shown(got), shown(exp)); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        string got, exp;
        set_in(12, 17, 321);
        @(posedge clk);
        repeat (225) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midreset_pre_busy: got %b required 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b required 1", tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy); end
        repeat (3) @(negedge clk);
        rx_q.delete();
        rst_n = 1'b1;
        wait_quiet(to);
        checks++;
        if (to) begin errors++; $display("FAIL midreset_timeout: busy did not settle"); end
        got = rx_str();
        exp = frame(12, 17, 321);
        checks++;
        if (got != exp) begin errors++; $display("FAIL midreset_frame: got '%s' required '%s'", shown(got), shown(exp)); end
    endtask

    task automatic test_random();
        bit to;
        string got, exp;
        int u, d, b, old_u, old_d, old_b;
        for (int n = 0; n < 8; n++) begin
            rx_q.delete();
            old_u = cur_u; old_d = cur_d; old_b = cur_b;
            if (n % 2 == 0) begin
                u = int'($urandom_range(63));
                d = int'($urandom_range(63));
                b = int'($urandom_range(1023));
                set_in(u, d, b);
                if (u == old_u && d == old_d && b == old_b) pulse_force();
                exp = frame(u, d, b);
            end else begin
                pulse_force();
                for (int j = 0; j < 3; j++) begin
                    repeat (int'($urandom_range(150, 30))) @(negedge clk);
                    set_in(int'($urandom_range(63)), int'($urandom_range(63)), int'($urandom_range(1023)));
                end
                exp = frame(old_u, old_d, old_b);
                if (cur_u != old_u || cur_d != old_d || cur_b != old_b)
                    exp = {exp, frame(cur_u, cur_d, cur_b)};
            end
            wait_quiet(to);
            checks++;
            if (to) begin errors++; $display("FAIL random_timeout_%0d: busy did not settle", n); end
            got = rx_str();
            checks++;
            if (got != exp) begin errors++; $display("FAIL random_frame_%0d: got '%s' required '%s'", n, shown(got), shown(exp)); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_mid_frame_changes();
        test_force();
        test_back_to_back();
        test_extremes();
        test_reset_mid_frame();
        test_random();
        checks++;
        if (rx_ferr != 0) begin errors++; $display("FAIL framing_errors: got %0d required 0", rx_ferr); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
